// File: rtl/lif_pkg.sv
// Shared widths, state encoding and sizing helpers for the LIF neuron and its
// synapse accumulator.
package lif_pkg;

    localparam int LIF_N_SYN = 4;
    localparam int LIF_V_W   = 12;
    localparam int LIF_W_W   = 8;
    localparam int LIF_TAU_W = 3;
    localparam int LIF_REF_W = 4;

    typedef enum logic {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } lif_state_e;

    // Width that holds N_SYN weights of W_W bits added together without overflow.
    function automatic int sum_width(input int n_syn, input int w_w);
        return w_w + $clog2(n_syn);
    endfunction

endpackage

// File: rtl/syn_accumulator.sv
// Combinational weighted sum of the active synapse events.
module syn_accumulator
    import lif_pkg::*;
#(
    parameter int N_SYN = LIF_N_SYN,
    parameter int W_W   = LIF_W_W
) (
    input  logic [N_SYN-1:0]                    syn,
    input  logic [N_SYN*W_W-1:0]                weight,
    output logic [sum_width(N_SYN, W_W)-1:0]    sum
);

    localparam int S_W = sum_width(N_SYN, W_W);

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (syn[i]) begin
                sum = sum + S_W'(weight[i*W_W +: W_W]);
            end
        end
    end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: saturating integration of weighted synapse
// events, shift-based leak, threshold spike, reset potential and refractory hold.
//
//   state         | meaning
//   --------------+------------------------------------------------------------
//   ST_INTEGRATE  | leak + integrate each enabled edge, spike on threshold
//   ST_REFRACTORY | V frozen, inputs ignored, down-counter runs to terminal 1
module lif_neuron
    import lif_pkg::*;
#(
    parameter int N_SYN = LIF_N_SYN,
    parameter int V_W   = LIF_V_W,
    parameter int W_W   = LIF_W_W,
    parameter int TAU_W = LIF_TAU_W,
    parameter int REF_W = LIF_REF_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_SYN-1:0]      syn,
    input  logic [N_SYN*W_W-1:0]  weight,
    input  logic [TAU_W-1:0]      tau_shift,
    input  logic [V_W-1:0]        threshold,
    input  logic [V_W-1:0]        v_reset,
    input  logic [REF_W-1:0]      refrac_len,
    output logic                  spike,
    output logic [V_W-1:0]        V,
    output logic                  refractory
);

    localparam int S_W = sum_width(N_SYN, W_W);
    localparam int C_W = V_W + $clog2(N_SYN) + 1;
    localparam logic [C_W-1:0] C_MAX = C_W'({V_W{1'b1}});

    lif_state_e       state_q, state_d;
    logic [V_W-1:0]   v_q, v_d;
    logic [REF_W-1:0] cnt_q, cnt_d;
    logic             spike_q, spike_d;

    logic [S_W-1:0]   syn_sum;
    logic [V_W-1:0]   leak;
    logic [C_W-1:0]   cand_full;
    logic [V_W-1:0]   cand;
    logic             fire;

    syn_accumulator #(
        .N_SYN (N_SYN),
        .W_W   (W_W)
    ) u_syn_acc (
        .syn    (syn),
        .weight (weight),
        .sum    (syn_sum)
    );

    // leak never exceeds v_q, so the subtraction cannot underflow
    assign leak      = v_q >> tau_shift;
    assign cand_full = C_W'(v_q) - C_W'(leak) + C_W'(syn_sum);
    assign cand      = (cand_full > C_MAX) ? {V_W{1'b1}} : cand_full[V_W-1:0];
    assign fire      = (cand >= threshold);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INTEGRATE;
            v_q     <= '0;
            cnt_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            spike_q <= spike_d;
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        spike_d = 1'b0;
        if (en) begin
            case (state_q)
                ST_INTEGRATE: begin
                    if (fire) begin
                        spike_d = 1'b1;
                        v_d     = v_reset;
                        if (refrac_len != '0) begin
                            state_d = ST_REFRACTORY;
                            cnt_d   = refrac_len;
                        end
                    end else begin
                        v_d = cand;
                    end
                end
                ST_REFRACTORY: begin
                    cnt_d = cnt_q - REF_W'(1);
                    // terminal count; <= also recovers from a stray zero count
                    if (cnt_q <= REF_W'(1)) begin
                        state_d = ST_INTEGRATE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_INTEGRATE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign spike      = spike_q;
    assign V          = v_q;
    assign refractory = (state_q == ST_REFRACTORY);

endmodule
